layer_seq_ctrl: RTL and testbench

- Sequencer for one fully-connected ANN layer using a single shared serial multiply-accumulate datapath.
- Time-multiplexes the datapath over NEURON_NUM neurons.
- For each neuron it fetches NEURON_WIDTH weight/input pairs and the bias from synchronous memories, accumulates, adds the bias, and applies the activation.
- Saturates each result and streams it out with a valid/ready handshake.
- Sits between the parameter/input buffers and the next layer's input buffer; this is the area-reduced alternative to a fully parallel neuron array.

---
 rtl/layer_seq_ctrl_if.sv | 43 ++++
 rtl/layer_seq_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_layer_seq_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/layer_seq_ctrl_if.sv
// Memory-read and result-stream bundle of the serial layer sequencer.
// Latency: none (wires only); rdata returns one cycle after rd_en.
// Backpressure: out_valid/out_ready; the memory ports never stall.
interface layer_seq_ctrl_if #(
  parameter int DATA_W       = 8,
  parameter int W_W          = 8,
  parameter int B_BITS       = 16,
  parameter int NEURON_NUM   = 4,
  parameter int NEURON_WIDTH = 4,
  parameter int OUT_W        = DATA_W + 8
);
  localparam int WA_W = (NEURON_NUM * NEURON_WIDTH > 1) ? $clog2(NEURON_NUM * NEURON_WIDTH) : 1;
  localparam int KA_W = (NEURON_WIDTH > 1) ? $clog2(NEURON_WIDTH) : 1;
  localparam int NA_W = (NEURON_NUM > 1) ? $clog2(NEURON_NUM) : 1;

  logic                     w_rd_en;
  logic [WA_W-1:0]          w_addr;
  logic signed [W_W-1:0]    w_rdata;
  logic                     x_rd_en;
  logic [KA_W-1:0]          x_addr;
  logic signed [DATA_W-1:0] x_rdata;
  logic                     b_rd_en;
  logic [NA_W-1:0]          b_addr;
  logic signed [B_BITS-1:0] b_rdata;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic [NA_W-1:0]          out_idx;

  // Sequencer side.
  modport master (
    output w_rd_en, w_addr, x_rd_en, x_addr, b_rd_en, b_addr,
    output out_valid, out_data, out_idx,
    input  w_rdata, x_rdata, b_rdata, out_ready
  );

  // Memories and downstream consumer side.
  modport slave (
    input  w_rd_en, w_addr, x_rd_en, x_addr, b_rd_en, b_addr,
    input  out_valid, out_data, out_idx,
    output w_rdata, x_rdata, b_rdata, out_ready
  );
endinterface

// File: rtl/layer_seq_ctrl.sv
// Serial MAC sequencer for one fully-connected layer; optional LAYER_SEQ_PERF_EN adds perf_cycles.
// Latency: NEURON_WIDTH+3 cycles per neuron from MAC entry to out_valid, done one cycle after last handshake.
// Backpressure: holds the result in EMIT while out_ready is low; every stall cycle delays all later events.
module layer_seq_ctrl #(
  parameter int DATA_W       = 8,
  parameter int W_W          = 8,
  parameter int B_BITS       = 16,
  parameter int NEURON_NUM   = 4,
  parameter int NEURON_WIDTH = 4,
  parameter int ACC_W        = 32,
  parameter int OUT_W        = DATA_W + 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic activation_func,
  output logic busy,
  output logic done,
`ifdef LAYER_SEQ_PERF_EN
  output logic [31:0] perf_cycles,
`endif
  layer_seq_ctrl_if.master bus
);
  localparam int WA_W = (NEURON_NUM * NEURON_WIDTH > 1) ? $clog2(NEURON_NUM * NEURON_WIDTH) : 1;
  localparam int KA_W = (NEURON_WIDTH > 1) ? $clog2(NEURON_WIDTH) : 1;
  localparam int NA_W = (NEURON_NUM > 1) ? $clog2(NEURON_NUM) : 1;
  localparam int PW   = DATA_W + W_W;

  localparam logic [KA_W-1:0] K_LAST = KA_W'(NEURON_WIDTH - 1);
  localparam logic [NA_W-1:0] N_LAST = NA_W'(NEURON_NUM - 1);
  // Output range expressed at bias-add width so the clamp compares like with like.
  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_DRAIN, S_POST, S_EMIT, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [NA_W-1:0]         n_q, n_d;
  logic [KA_W-1:0]         k_q, k_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [B_BITS-1:0] bias_q, bias_d;
  logic                    relu_q, relu_d;
  logic                    prod_pend_q, bias_pend_q;
  logic                    out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;
  logic [NA_W-1:0]         out_idx_q, out_idx_d;

  logic                    mac_rd;
  logic                    bias_rd;
  logic signed [PW-1:0]    w_ext, x_ext, prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W:0]   sum, sum_act;
  logic signed [OUT_W-1:0] sat;

  // Datapath: product of last cycle's read pair, bias add, activation and clamp.
  always_comb begin
    w_ext    = {{DATA_W{bus.w_rdata[W_W-1]}}, bus.w_rdata};
    x_ext    = {{W_W{bus.x_rdata[DATA_W-1]}}, bus.x_rdata};
    prod     = w_ext * x_ext;
    prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
    sum      = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-B_BITS){bias_q[B_BITS-1]}}, bias_q};
    sum_act  = (relu_q && sum[ACC_W]) ? '0 : sum;
    if (sum_act > SAT_MAX)      sat = OUT_MAX;
    else if (sum_act < SAT_MIN) sat = OUT_MIN;
    else                        sat = sum_act[OUT_W-1:0];
  end

  // Next-state and read-issue logic; pending read data is folded in whatever the state.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    k_d         = k_q;
    acc_d       = acc_q;
    bias_d      = bias_q;
    relu_d      = relu_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    mac_rd      = 1'b0;
    if (prod_pend_q) acc_d  = acc_q + prod_ext;
    if (bias_pend_q) bias_d = bus.b_rdata;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_MAC;
          n_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          relu_d  = activation_func;
        end
      end
      S_MAC: begin
        mac_rd = 1'b1;
        if (k_q == K_LAST) state_d = S_DRAIN;
        else               k_d = k_q + 1'b1;
      end
      S_DRAIN: state_d = S_POST;
      S_POST: begin
        out_data_d  = sat;
        out_idx_d   = n_q;
        out_valid_d = 1'b1;
        state_d     = S_EMIT;
      end
      S_EMIT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (n_q == N_LAST) begin
            state_d = S_DONE;
          end else begin
            n_d     = n_q + 1'b1;
            k_d     = '0;
            acc_d   = '0;
            state_d = S_MAC;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bias_rd = mac_rd && (k_q == '0);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      bias_q      <= '0;
      relu_q      <= 1'b0;
      prod_pend_q <= 1'b0;
      bias_pend_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      bias_q      <= bias_d;
      relu_q      <= relu_d;
      prod_pend_q <= mac_rd;
      bias_pend_q <= bias_rd;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign busy          = (state_q == S_MAC) || (state_q == S_DRAIN) ||
                         (state_q == S_POST) || (state_q == S_EMIT);
  assign done          = (state_q == S_DONE);
  assign bus.w_rd_en   = mac_rd;
  assign bus.x_rd_en   = mac_rd;
  assign bus.b_rd_en   = bias_rd;
  assign bus.w_addr    = WA_W'(n_q) * WA_W'(NEURON_WIDTH) + WA_W'(k_q);
  assign bus.x_addr    = k_q;
  assign bus.b_addr    = n_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;

`ifdef LAYER_SEQ_PERF_EN
  logic [31:0] perf_cycles_q;

  // Busy-cycle counter: cleared by an accepted start, saturates, holds while idle.
  always_ff @(posedge clk) begin
    if (rst)                              perf_cycles_q <= '0;
    else if (state_q == S_IDLE && start)  perf_cycles_q <= '0;
    else if (busy && perf_cycles_q != '1) perf_cycles_q <= perf_cycles_q + 1'b1;
  end

  assign perf_cycles = perf_cycles_q;
`endif
endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Scoreboard bench for layer_seq_ctrl: reference results queued at start, checked at each handshake.
// Latency: expected handshake and done cycles derived from NEURON_WIDTH+3 per neuron plus stalls.
// Backpressure: directed and random out_ready stalls, with hold-stability checks while stalled.
module tb_layer_seq_ctrl;
  localparam int NN    = 4;
  localparam int NW    = 4;
  localparam int OUT_W = 16;
  localparam int PER_N = NW + 3;

  logic clk = 1'b0;
  logic rst, start, act;
  logic busy, done;
`ifdef LAYER_SEQ_PERF_EN
  logic [31:0] perf_cycles;
`endif

  layer_seq_ctrl_if bus ();

  layer_seq_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .activation_func (act),
    .busy            (busy),
    .done            (done),
`ifdef LAYER_SEQ_PERF_EN
    .perf_cycles     (perf_cycles),
`endif
    .bus             (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Parameter/input memories, one-cycle read latency.
  int wm [NN*NW];
  int xm [NW];
  int bm [NN];
  always @(posedge clk) begin
    if (bus.w_rd_en) bus.w_rdata <= 8'(wm[bus.w_addr]);
    if (bus.x_rd_en) bus.x_rdata <= 8'(xm[bus.x_addr]);
    if (bus.b_rd_en) bus.b_rdata <= 16'(bm[bus.b_addr]);
  end

  typedef struct {int idx; int data; int cyc;} exp_t;
  exp_t q[$];
  exp_t e;
  int  total = 0;
  int  bad = 0;
  bit  exp_done = 0;
  int  exp_done_cyc = -1;
  bit  stall_prev = 0;
  int  held_data, held_idx;

  task automatic chk(input string name, input longint actual, input longint expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference: dot product plus bias, optional ReLU, clamp to the output range.
  function automatic int ref_out(input int n, input bit relu);
    longint s;
    longint hi, lo;
    hi = (longint'(1) <<< (OUT_W - 1)) - 1;
    lo = -(longint'(1) <<< (OUT_W - 1));
    s = bm[n];
    for (int k = 0; k < NW; k++) s += longint'(wm[n*NW+k]) * longint'(xm[k]);
    if (relu && s < 0) s = 0;
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    return int'(s);
  endfunction

  // Monitor: pop and compare on every handshake, check holds while stalled and done timing.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 0;
    end else begin
      if (bus.out_valid) begin
        if (stall_prev) begin
          chk("hold_data", longint'(bus.out_data), held_data);
          chk("hold_idx", bus.out_idx, held_idx);
        end
        if (bus.out_ready) begin
          if (q.size() == 0) begin
            chk("spurious_out_valid", bus.out_valid, 0);
          end else begin
            e = q.pop_front();
            chk("out_data", longint'(bus.out_data), e.data);
            chk("out_idx", bus.out_idx, e.idx);
            if (e.cyc >= 0) chk("out_cycle", cyc, e.cyc);
          end
          stall_prev = 0;
        end else begin
          stall_prev = 1;
          held_data  = int'(bus.out_data);
          held_idx   = int'(bus.out_idx);
        end
      end else begin
        stall_prev = 0;
      end
      if (done) begin
        if (!exp_done) begin
          chk("spurious_done", done, 0);
        end else begin
          if (exp_done_cyc >= 0) chk("done_cycle", cyc, exp_done_cyc);
          chk("outputs_left_at_done", q.size(), 0);
          exp_done = 0;
        end
      end
    end
  end

  task automatic run_layer(input bit relu, input int stall, input bit rnd_ready,
                           input int restart_t, input int rst_t);
    int  c0;
    bit  det;
    exp_t ex;
    det = !rnd_ready && (rst_t < 0);
    @(posedge clk); #1;
    c0    = cyc;
    act   = relu;
    start = 1'b1;
    if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    else           bus.out_ready = (stall == 0);
    for (int j = 0; j < NN; j++) begin
      ex.idx  = j;
      ex.data = ref_out(j, relu);
      ex.cyc  = rnd_ready ? -1 : c0 + (j + 1) * PER_N + stall;
      q.push_back(ex);
    end
    exp_done     = 1;
    exp_done_cyc = rnd_ready ? -1 : c0 + NN * PER_N + 1 + stall;
    for (int t = 1; t < 600 && exp_done; t++) begin
      @(posedge clk); #1;
      start = (t == restart_t);
      act   = ~relu;
      if (rnd_ready)      bus.out_ready = ($urandom_range(0, 3) != 0);
      else if (stall > 0) bus.out_ready = (t >= PER_N + stall);
      if (det) chk("busy", busy, (t >= 1 && t <= NN * PER_N + stall));
      if (t == rst_t) rst = 1'b1;
      if (rst_t >= 0 && t == rst_t + 1) begin
        rst = 1'b0;
        chk("busy_after_rst", busy, 0);
        chk("out_valid_after_rst", bus.out_valid, 0);
        q.delete();
        exp_done = 0;
      end
    end
    if (exp_done) begin
      chk("done_timeout", exp_done, 0);
      exp_done = 0;
      q.delete();
    end
    start = 1'b0;
    rst   = 1'b0;
    bus.out_ready = 1'b1;
`ifdef LAYER_SEQ_PERF_EN
    if (det) chk("perf_cycles", perf_cycles, NN * PER_N + stall);
`endif
    repeat (rst_t >= 0 ? 40 : 3) @(posedge clk);
  endtask

  task automatic load_basic();
    for (int i = 0; i < NN*NW; i++) wm[i] = 1;
    for (int k = 0; k < NW; k++) xm[k] = k + 1;
    for (int n = 0; n < NN; n++) bm[n] = 0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    act = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_w_rd_en", bus.w_rd_en, 0);
    chk("rst_x_rd_en", bus.x_rd_en, 0);
    chk("rst_b_rd_en", bus.b_rd_en, 0);
    chk("rst_w_addr", bus.w_addr, 0);
    chk("rst_x_addr", bus.x_addr, 0);
    chk("rst_b_addr", bus.b_addr, 0);
    chk("rst_out_data", longint'(bus.out_data), 0);
    chk("rst_out_idx", bus.out_idx, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Unit weights, ramp inputs, identity.
    load_basic();
    run_layer(1'b0, 0, 1'b0, -1, -1);

    // Negative weights with bias, identity then ReLU.
    for (int i = 0; i < NN*NW; i++) wm[i] = -1;
    bm[0] = 5; bm[1] = 0; bm[2] = 0; bm[3] = 20;
    run_layer(1'b0, 0, 1'b0, -1, -1);
    run_layer(1'b1, 0, 1'b0, -1, -1);

    // Saturation at both ends.
    for (int i = 0; i < NN*NW; i++) wm[i] = 127;
    for (int k = 0; k < NW; k++) xm[k] = 127;
    for (int n = 0; n < NN; n++) bm[n] = 32767;
    run_layer(1'b0, 0, 1'b0, -1, -1);
    for (int k = 0; k < NW; k++) xm[k] = -128;
    for (int n = 0; n < NN; n++) bm[n] = -32768;
    run_layer(1'b0, 0, 1'b0, -1, -1);

    // Five-cycle stall at the first result.
    load_basic();
    run_layer(1'b0, 5, 1'b0, -1, -1);

    // Reset mid-run, then a clean rerun.
    run_layer(1'b0, 0, 1'b0, -1, 10);
    run_layer(1'b0, 0, 1'b0, -1, -1);

    // Second start while busy is ignored.
    run_layer(1'b0, 0, 1'b0, 3, -1);

    // Random data, activation and downstream readiness.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NN*NW; i++) wm[i] = int'($urandom_range(0, 255)) - 128;
      for (int k = 0; k < NW; k++) xm[k] = int'($urandom_range(0, 255)) - 128;
      for (int n = 0; n < NN; n++) bm[n] = int'($urandom_range(0, 65535)) - 32768;
      run_layer(1'($urandom_range(0, 1)), 0, 1'b1, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
